// File: rtl/bus_responder.sv
// ---------------------------------------------------------------------------
// bus_responder: sole CPU bus target - async-read RAM, I/O page, host loader.
// Optional macro RESP_WPROT_EN: CPU write protection below WP_LIMIT. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_responder #(
  parameter int DEPTH    = 2048,
  parameter int PRESCALE = 16,
  parameter int WP_LIMIT = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] bus_addr,
  input  logic        bus_we,
  input  logic [3:0]  bus_data_in,
  output logic [3:0]  bus_data_out,
  output logic        bus_data_oe,
  input  logic [3:0]  in_port,
  output logic [3:0]  out_port,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [11:0] load_addr,
  input  logic [3:0]  load_data,
  output logic        wp_fault
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          PW      = $clog2(PRESCALE);
  localparam logic [12:0] DEPTH_C = 13'(DEPTH);
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

  localparam logic [11:0] A_OUT    = 12'hFF0;
  localparam logic [11:0] A_IN     = 12'hFF1;
  localparam logic [11:0] A_TIMER  = 12'hFF2;
  localparam logic [11:0] A_STATUS = 12'hFF3;

  logic [3:0]    mem [DEPTH];
  logic [3:0]    out_q, out_d;
  logic [3:0]    timer_q, timer_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic          wp_fault_q, wp_fault_d;

  logic          cpu_ram;
  logic          ld_ram;
  logic          wp_hit;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [3:0]    ram_wdata;

  assign cpu_ram = ({1'b0, bus_addr} < DEPTH_C);
  assign ld_ram  = ({1'b0, load_addr} < DEPTH_C);

`ifdef RESP_WPROT_EN
  localparam logic [12:0] WP_C = 13'(WP_LIMIT);
  assign wp_hit = bus_we & ({1'b0, bus_addr} < WP_C);
`else
  assign wp_hit = 1'b0;
`endif

  // CPU owns the RAM port whenever it writes RAM, even if that write is protected
  assign load_ready  = ~(bus_we & cpu_ram);
  assign bus_data_oe = ~bus_we;
  assign out_port    = out_q;
  assign wp_fault    = wp_fault_q;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = bus_addr[AW-1:0];
    ram_wdata = bus_data_in;
    if (bus_we & cpu_ram & ~wp_hit) begin
      ram_we = 1'b1;
    end else if (load_valid & load_ready & ld_ram) begin
      ram_we    = 1'b1;
      ram_waddr = load_addr[AW-1:0];
      ram_wdata = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

  always_comb begin
    bus_data_out = 4'hF;
    if (cpu_ram) begin
      bus_data_out = mem[bus_addr[AW-1:0]];
    end else begin
      case (bus_addr)
        A_OUT:    bus_data_out = out_q;
        A_IN:     bus_data_out = sync2_q;
        A_TIMER:  bus_data_out = timer_q;
        A_STATUS: bus_data_out = {3'b000, wp_fault_q};
        default:  bus_data_out = 4'hF;
      endcase
    end
  end

  always_comb begin
    out_d   = out_q;
    timer_d = timer_q;
    sync1_d = in_port;
    sync2_d = sync1_q;
    if (pre_q == PS_MAX) begin
      pre_d   = '0;
      timer_d = timer_q + 4'd1;
    end else begin
      pre_d = pre_q + 1'b1;
    end
    // a timer load overrides any increment on the same edge
    if (bus_we) begin
      case (bus_addr)
        A_OUT: out_d = bus_data_in;
        A_TIMER: begin
          timer_d = bus_data_in;
          pre_d   = '0;
        end
        default: ;
      endcase
    end
`ifdef RESP_WPROT_EN
    wp_fault_d = wp_hit |
                 (wp_fault_q & ~(bus_we & (bus_addr == A_STATUS) & bus_data_in[0]));
`else
    wp_fault_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q      <= 4'h0;
      timer_q    <= 4'h0;
      pre_q      <= '0;
      sync1_q    <= 4'h0;
      sync2_q    <= 4'h0;
      wp_fault_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      timer_q    <= timer_d;
      pre_q      <= pre_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      wp_fault_q <= wp_fault_d;
    end
  end

endmodule

`default_nettype wire
